// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// The upstream ready depends only on registered state, so the downstream ready never
// reaches it combinationally. Side-effect control bits are driven only in the first
// cycle an entry sits at the head. Bubbles are presented as all-zero payloads.
module pipe_stage_buf #(
  parameter int unsigned              DATA_W    = 96,
  parameter int unsigned              CTRL_W    = 16,
  parameter logic [CTRL_W-1:0]        SIDE_MASK = {CTRL_W{1'b0}},
  parameter int unsigned              CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   head_data_q;
  logic [CTRL_W-1:0]   head_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic                fresh_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic                accept;
  logic                pop;
  logic [CTRL_W-1:0]   side_gate;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Handshake and occupancy derived purely from registered state.
  always_comb begin
    in_ready  = (state_q != StTwo);
    out_valid = (state_q != StEmpty);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Output gating: bubbles read as zero, side bits only while the head entry is fresh.
  always_comb begin
    side_gate = fresh_q ? {CTRL_W{1'b1}} : ~SIDE_MASK;
    out_data  = out_valid ? head_data_q : {DATA_W{1'b0}};
    out_ctrl  = out_valid ? (head_ctrl_q & side_gate) : {CTRL_W{1'b0}};
    stall_cnt = stall_cnt_q;
  end

  // Stage FSM: head/skid storage and freshness tracking; flush outranks all traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      fresh_q     <= 1'b0;
    end else if (flush) begin
      // A pop in this cycle still completes downstream; any offered input is dropped.
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      fresh_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_data_q <= in_data;
            head_ctrl_q <= in_ctrl;
            fresh_q     <= 1'b1;
            state_q     <= StOne;
          end else begin
            fresh_q <= 1'b0;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_data_q <= in_data;
            head_ctrl_q <= in_ctrl;
            fresh_q     <= 1'b1;
          end else if (accept) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
            fresh_q     <= 1'b0;
            state_q     <= StTwo;
          end else if (pop) begin
            fresh_q <= 1'b0;
            state_q <= StEmpty;
          end else begin
            fresh_q <= 1'b0;
          end
        end
        StTwo: begin
          if (pop) begin
            head_data_q <= skid_data_q;
            head_ctrl_q <= skid_ctrl_q;
            fresh_q     <= 1'b1;
            state_q     <= StOne;
          end else begin
            fresh_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StEmpty;
          fresh_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment and flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_q <= stall_cnt_q + CntOne;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure, side bits,
// flush and stall-counter saturation, checked with immediate assertions.
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_cnt_clr;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .SIDE_MASK (16'h0003),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .occupancy     (occupancy),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (stall_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b1;
    in_data       = 8'hA5;
    in_ctrl       = 16'h0000;
    out_ready     = 1'b0;
    stall_cnt_clr = 1'b0;

    // Reset with an offered entry that must not be captured.
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    tick();
    chk("rst_no_capture", 32'(out_valid), 32'd0);

    // Streaming with out_ready held high: one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      tick();
      chk("stream_data",  32'(out_data),  32'(k));
      chk("stream_occ",   32'(occupancy), 32'd1);
      chk("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_occ", 32'(occupancy), 32'd0);
    chk("stream_stall",     32'(stall_cnt), 32'd0);

    // Backpressure: fill both entries, hold off a third, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    chk("bp_first", 32'(out_data), 32'h11);
    in_data = 8'h22;
    tick();
    chk("bp_occ2",   32'(occupancy), 32'd2);
    chk("bp_nready", 32'(in_ready),  32'd0);
    in_data = 8'h33;
    tick();
    tick();
    chk("bp_hold_head", 32'(out_data),  32'h11);
    chk("bp_hold_occ",  32'(occupancy), 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 32'(out_data),  32'h22);
    chk("bp_occ1",   32'(occupancy), 32'd1);
    tick();
    chk("bp_third", 32'(out_data), 32'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_stall", 32'(stall_cnt), 32'd3);

    // Side bits: only the first head cycle carries them.
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    in_ctrl   = 16'h0103;
    tick();
    chk("side_c1", 32'(out_ctrl), 32'h0103);
    in_valid = 1'b0;
    in_ctrl  = 16'h0000;
    tick();
    chk("side_c2", 32'(out_ctrl), 32'h0100);
    tick();
    chk("side_c3", 32'(out_ctrl), 32'h0100);
    tick();
    chk("side_c4",   32'(out_ctrl), 32'h0100);
    chk("side_data", 32'(out_data), 32'h44);
    out_ready = 1'b1;
    tick();
    chk("side_bubble_ctrl", 32'(out_ctrl), 32'h0000);
    chk("side_stall",       32'(stall_cnt), 32'd3);

    // Flush from TWO with an input offered in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick();
    in_data = 8'h66;
    tick();
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    in_data = 8'h77;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_data",  32'(out_data),  32'd0);
    chk("fl_occ",   32'(occupancy), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_nothing", 32'(out_valid), 32'd0);
    end

    // Stall counter saturation and clear priority.
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("sat_clr0", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h88;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    chk("sat_clr", 32'(stall_cnt), 32'd0);
    tick();
    chk("sat_restart", 32'(stall_cnt), 32'd1);

    // Asynchronous reset mid-operation clears state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ",   32'(occupancy), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
